player_control: RTL and testbench

Per-frame player-car state engine, the producer of the position that the player sprite plotter consumes. Samples two USB HID keycodes once per video frame and updates the car's top-left corner (`PlayerX`, `PlayerY`), a 3-bit speed and a crash flag. Runs in the `clk` domain and detects frame boundaries from the VGA vertical-sync-derived `frame_clk`. Outputs feed the sprite plotter, road scroller and collision logic.

---
 rtl/player_control.sv | 169 ++++++++++++++++
 tb/tb_player_control.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/player_control.sv
// Per-frame player-car state engine: samples keys and collision once per video
// frame and updates car position, speed and crash status for the plotter.
module player_control #(
    parameter int START_X      = 296,
    parameter int PLAYER_Y     = 400,
    parameter int CAR_W        = 47,
    parameter int X_MIN        = 160,
    parameter int X_MAX        = 480,
    parameter int LAT_STEP     = 4,
    parameter int MAX_SPEED    = 7,
    parameter int ACCEL_FRAMES = 4,
    parameter int COAST_FRAMES = 8,
    parameter int CRASH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic       collide,
    output logic [9:0] PlayerX,
    output logic [9:0] PlayerY,
    output logic [2:0] Speed,
    output logic       Crashed
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] CRASH = 2'd2;

    localparam int AW = $clog2(ACCEL_FRAMES + 1);
    localparam int CW = $clog2(COAST_FRAMES + 1);
    localparam int KW = $clog2(CRASH_FRAMES + 1);

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    logic [1:0]    state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q;
    logic [2:0]    speed_q, speed_d;
    logic          crashed_q, crashed_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] coast_q, coast_d;
    logic [KW-1:0] crash_cnt_q, crash_cnt_d;
    logic          f1_q, f2_q;

    logic        tick;
    logic        key_w, key_s, key_a, key_d;
    logic [10:0] x_plus;

    assign tick  = f1_q & ~f2_q;
    assign key_w = (keycode0 == KEY_W) | (keycode1 == KEY_W);
    assign key_s = (keycode0 == KEY_S) | (keycode1 == KEY_S);
    assign key_a = (keycode0 == KEY_A) | (keycode1 == KEY_A);
    assign key_d = (keycode0 == KEY_D) | (keycode1 == KEY_D);

    // Right-edge sum is one bit wider so a large PlayerX cannot wrap.
    assign x_plus = {1'b0, x_q} + 11'(LAT_STEP);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path
        // through the case leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        x_d         = x_q;
        speed_d     = speed_q;
        crashed_d   = crashed_q;
        acc_d       = acc_q;
        coast_d     = coast_q;
        crash_cnt_d = crash_cnt_q;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (key_w) state_d = RUN;
                end
                RUN: begin
                    if (collide) begin
                        state_d     = CRASH;
                        speed_d     = 3'd0;
                        crashed_d   = 1'b1;
                        crash_cnt_d = KW'(CRASH_FRAMES);
                        acc_d       = '0;
                        coast_d     = '0;
                    end else begin
                        if (key_s) begin
                            if (speed_q != 3'd0) speed_d = speed_q - 3'd1;
                            acc_d   = '0;
                            coast_d = '0;
                        end else if (key_w) begin
                            coast_d = '0;
                            if (acc_q == AW'(ACCEL_FRAMES - 1)) begin
                                acc_d = '0;
                                if (speed_q != 3'(MAX_SPEED)) speed_d = speed_q + 3'd1;
                            end else begin
                                acc_d = acc_q + AW'(1);
                            end
                        end else begin
                            acc_d = '0;
                            if (coast_q == CW'(COAST_FRAMES - 1)) begin
                                coast_d = '0;
                                if (speed_q != 3'd0) speed_d = speed_q - 3'd1;
                            end else begin
                                coast_d = coast_q + CW'(1);
                            end
                        end

                        if (speed_q != 3'd0) begin
                            if (key_a && !key_d) begin
                                if (x_q < 10'(X_MIN + LAT_STEP)) x_d = 10'(X_MIN);
                                else                             x_d = x_q - 10'(LAT_STEP);
                            end else if (key_d && !key_a) begin
                                if (x_plus > 11'(X_MAX - CAR_W)) x_d = 10'(X_MAX - CAR_W);
                                else                             x_d = x_plus[9:0];
                            end
                        end
                    end
                end
                CRASH: begin
                    if (crash_cnt_q == KW'(1)) begin
                        crash_cnt_d = '0;
                        state_d     = RUN;
                        crashed_d   = 1'b0;
                        x_d         = 10'(START_X);
                    end else begin
                        crash_cnt_d = crash_cnt_q - KW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            x_q         <= 10'(START_X);
            y_q         <= 10'(PLAYER_Y);
            speed_q     <= 3'd0;
            crashed_q   <= 1'b0;
            acc_q       <= '0;
            coast_q     <= '0;
            crash_cnt_q <= '0;
            f1_q        <= 1'b0;
            f2_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= 10'(PLAYER_Y);
            speed_q     <= speed_d;
            crashed_q   <= crashed_d;
            acc_q       <= acc_d;
            coast_q     <= coast_d;
            crash_cnt_q <= crash_cnt_d;
            f1_q        <= frame_clk;
            f2_q        <= f1_q;
        end
    end

    assign PlayerX = x_q;
    assign PlayerY = y_q;
    assign Speed   = speed_q;
    assign Crashed = crashed_q;

endmodule

// File: tb/tb_player_control.sv
// Scoreboard bench for player_control: each frame of stimulus queues its
// expected outputs, and a monitor compares them once the frame has settled.
module tb_player_control;

    localparam logic [7:0] W = 8'h1A;
    localparam logic [7:0] S = 8'h16;
    localparam logic [7:0] A = 8'h04;
    localparam logic [7:0] D = 8'h07;
    localparam logic [7:0] N = 8'h00;

    logic       clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode0, keycode1;
    logic       collide;
    logic [9:0] PlayerX, PlayerY;
    logic [2:0] Speed;
    logic       Crashed;

    typedef struct {
        string name;
        int    x;
        int    spd;
        int    crashed;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    player_control dut (
        .clk      (clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .keycode0 (keycode0),
        .keycode1 (keycode1),
        .collide  (collide),
        .PlayerX  (PlayerX),
        .PlayerY  (PlayerY),
        .Speed    (Speed),
        .Crashed  (Crashed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_out(input string name, input int x, input int spd, input int cr);
        exp_t e;
        e.name = name; e.x = x; e.spd = spd; e.crashed = cr;
        sb_q.push_back(e);
    endtask

    // One video frame: keys held across a frame_clk pulse of `hold` cycles.
    task automatic frame(input logic [7:0] k0, input logic [7:0] k1, input logic col,
                         input int hold, input string name,
                         input int x, input int spd, input int cr);
        keycode0 = k0; keycode1 = k1; collide = col;
        @(posedge clk); #1 frame_clk = 1'b1;
        repeat (hold) @(posedge clk);
        #1 frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 keycode0 = N; keycode1 = N; collide = 1'b0;
        expect_out(name, x, spd, cr);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".x"},   int'(PlayerX), e.x);
            check({e.name, ".y"},   int'(PlayerY), 400);
            check({e.name, ".spd"}, int'(Speed),   e.spd);
            check({e.name, ".cr"},  int'(Crashed), e.crashed);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; keycode0 = N; keycode1 = N; collide = 1'b0;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        expect_out("reset", 296, 0, 0);

        // IDLE -> RUN, speed untouched on the entry tick.
        frame(W, N, 1'b0, 3, "start", 296, 0, 0);

        // Speed steps every 4th frame, saturating at 7.
        for (int k = 1; k <= 40; k++)
            frame(W, N, 1'b0, 3, $sformatf("accel%0d", k), 296, (k / 4 > 7) ? 7 : k / 4, 0);

        // S wins over W on the other port.
        for (int k = 1; k <= 3; k++)
            frame(S, W, 1'b0, 3, $sformatf("brake%0d", k), 296, 7 - k, 0);

        // Right drift to the clamp at 433.
        for (int k = 1; k <= 36; k++)
            frame(D, W, 1'b0, 3, $sformatf("right%0d", k),
                  (296 + 4 * k > 433) ? 433 : 296 + 4 * k,
                  (4 + k / 4 > 7) ? 7 : 4 + k / 4, 0);

        // Left drift; 161 clamps to 160 rather than stepping below.
        for (int k = 1; k <= 72; k++)
            frame(W, A, 1'b0, 3, $sformatf("left%0d", k),
                  (433 - 4 * k < 160) ? 160 : 433 - 4 * k, 7, 0);

        // A and D together hold position.
        for (int k = 1; k <= 2; k++)
            frame(A, D, 1'b0, 3, $sformatf("ad%0d", k), 160, 7, 0);

        // frame_clk held high for 1000 cycles must give a single step.
        frame(D, W, 1'b0, 1000, "longframe", 164, 7, 0);

        // Crash: entry tick plus 59 ticks crashed, keys ignored, 60th exits.
        frame(W, D, 1'b1, 3, "crash_in", 164, 0, 1);
        for (int k = 1; k <= 59; k++)
            frame(W, A, 1'b0, 3, $sformatf("crash%0d", k), 164, 0, 1);
        frame(W, A, 1'b0, 3, "crash_out", 296, 0, 0);
        frame(W, D, 1'b0, 3, "post_crash", 296, 0, 0);

        // Reset during CRASH returns to IDLE; IDLE then ignores collide.
        frame(N, N, 1'b1, 3, "crash2_in", 296, 0, 1);
        for (int k = 1; k <= 3; k++)
            frame(D, N, 1'b0, 3, $sformatf("crash2_%0d", k), 296, 0, 1);
        @(posedge clk); #1 Reset = 1'b1;
        @(posedge clk); #1 Reset = 1'b0;
        expect_out("reset_mid_crash", 296, 0, 0);
        repeat (3) @(posedge clk);
        frame(W, N, 1'b1, 3, "idle_collide", 296, 0, 0);
        frame(N, N, 1'b1, 3, "run_collide", 296, 0, 1);

        repeat (10) @(posedge clk);
        if (sb_q.size() != 0) check("drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
